// File: rtl/detect_hit_if.sv
// vga_if: one VGA pixel-stream beat (raster position, sync, blanking, colour).
//   in  : consumer view, every field is an input
//   out : producer view, every field is an output
interface vga_if;
   logic [11:0] hcount;
   logic [11:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/detect_hit.sv
// detect_hit: shot resolution stage behind the mouse-cursor overlay.
// A rising edge on the left button latches the mouse position; when the raster
// reaches that visible pixel its colour is compared against KEY_COLOR and a
// one-cycle hit or miss pulse is issued. A shot that never meets its pixel
// resolves as a miss on the second frame start after arming. Clicks are
// ignored until a cooldown of COOLDOWN_FRAMES frame starts has elapsed.
// Ports:
//   clk, rst         pixel clock, synchronous active-high reset
//   x_pos, y_pos     mouse position (pixel clock domain)
//   left             left mouse button level
//   in               upstream VGA stream
//   out              the in stream registered by one cycle
//   hit, miss        one-cycle result pulses
//   hit_count        saturating count of hits
module detect_hit #(
   parameter logic [11:0] KEY_COLOR       = 12'h842,
   parameter int unsigned H_ACTIVE        = 800,
   parameter int unsigned V_ACTIVE        = 600,
   parameter int unsigned COOLDOWN_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] x_pos,
   input  logic [11:0] y_pos,
   input  logic        left,
   vga_if.in           in,
   vga_if.out          out,
   output logic        hit,
   output logic        miss,
   output logic [7:0]  hit_count
);

   localparam logic [11:0] H_LIM   = 12'(H_ACTIVE);
   localparam logic [11:0] V_LIM   = 12'(V_ACTIVE);
   localparam logic [7:0]  CD_LAST = (COOLDOWN_FRAMES == 0) ? 8'd0 : 8'(COOLDOWN_FRAMES - 1);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      RESULT_HIT,
      RESULT_MISS,
      COOLDOWN
   } state_t;

   state_t      state, state_nx;
   logic [7:0]  fc, fc_nx;
   logic [11:0] x_l, x_l_nx;
   logic [11:0] y_l, y_l_nx;
   logic        on_scr, on_scr_nx;
   logic        left_q;
   logic        rst_q;
   logic        click;
   logic        fs;
   logic        at_target;

   // rst_q masks the first cycle after reset so a button held through reset
   // is absorbed into left_q instead of being seen as a fresh press.
   assign click = left & ~left_q & ~rst_q;
   assign fs    = (in.hcount == '0) & (in.vcount == '0);

   // on_scr is redundant with the blanking qualifiers for a well-formed
   // raster, but keeps an off-screen shot from matching a malformed stream.
   assign at_target = on_scr & (in.hcount == x_l) & (in.vcount == y_l) &
                      ~in.hblnk & ~in.vblnk;

   always_ff @(posedge clk) begin
      if (rst) begin
         out.hcount <= '0;
         out.vcount <= '0;
         out.hsync  <= 1'b0;
         out.vsync  <= 1'b0;
         out.hblnk  <= 1'b0;
         out.vblnk  <= 1'b0;
         out.rgb    <= '0;
         left_q     <= 1'b0;
         rst_q      <= 1'b1;
         state      <= IDLE;
         fc         <= '0;
         x_l        <= '0;
         y_l        <= '0;
         on_scr     <= 1'b0;
         hit_count  <= '0;
      end else begin
         out.hcount <= in.hcount;
         out.vcount <= in.vcount;
         out.hsync  <= in.hsync;
         out.vsync  <= in.vsync;
         out.hblnk  <= in.hblnk;
         out.vblnk  <= in.vblnk;
         out.rgb    <= in.rgb;
         left_q     <= left;
         rst_q      <= 1'b0;
         state      <= state_nx;
         fc         <= fc_nx;
         x_l        <= x_l_nx;
         y_l        <= y_l_nx;
         on_scr     <= on_scr_nx;
         if ((state == RESULT_HIT) && (hit_count != '1))
            hit_count <= hit_count + 8'd1;
      end
   end

   always_comb begin
      state_nx  = state;
      fc_nx     = fc;
      x_l_nx    = x_l;
      y_l_nx    = y_l;
      on_scr_nx = on_scr;
      hit       = 1'b0;
      miss      = 1'b0;
      case (state)
         IDLE: begin
            if (click) begin
               x_l_nx    = x_pos;
               y_l_nx    = y_pos;
               on_scr_nx = (x_pos < H_LIM) & (y_pos < V_LIM);
               fc_nx     = '0;
               state_nx  = ARMED;
            end
         end
         ARMED: begin
            if (at_target) begin
               state_nx = (in.rgb == KEY_COLOR) ? RESULT_HIT : RESULT_MISS;
            end else if (fs) begin
               fc_nx = fc + 8'd1;
               if (fc == 8'd1)
                  state_nx = RESULT_MISS;
            end
         end
         RESULT_HIT: begin
            hit      = 1'b1;
            fc_nx    = '0;
            state_nx = COOLDOWN;
         end
         RESULT_MISS: begin
            miss     = 1'b1;
            fc_nx    = '0;
            state_nx = COOLDOWN;
         end
         COOLDOWN: begin
            if (COOLDOWN_FRAMES == 0) begin
               state_nx = IDLE;
            end else if (fs) begin
               fc_nx = fc + 8'd1;
               if (fc == CD_LAST)
                  state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_detect_hit.sv
// tb_detect_hit: scoreboard bench for detect_hit on a small 8x6 raster
// (6x4 visible). Each accepted click pushes the expected result and the raster
// position at which it must appear; a per-cycle monitor checks pass-through,
// pulses and the hit counter.
module tb_detect_hit;
   localparam logic [11:0] KEY = 12'h842;
   localparam int HA = 6;
   localparam int VA = 4;
   localparam int HT = 8;
   localparam int VT = 6;
   localparam int FT = HT * VT;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] x_pos;
   logic [11:0] y_pos;
   logic        left;
   logic        hit;
   logic        miss;
   logic [7:0]  hit_count;

   vga_if in_if ();
   vga_if out_if ();

   detect_hit #(
      .KEY_COLOR       (KEY),
      .H_ACTIVE        (HA),
      .V_ACTIVE        (VA),
      .COOLDOWN_FRAMES (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .x_pos     (x_pos),
      .y_pos     (y_pos),
      .left      (left),
      .in        (in_if),
      .out       (out_if),
      .hit       (hit),
      .miss      (miss),
      .hit_count (hit_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int abs;
      bit is_hit;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          drv_abs = 0;
   int          samp_abs;
   logic [39:0] samp_vec;
   logic        rst_s;
   int          exp_count = 0;
   int          busy_until = 0;
   int          last_res = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_key(input int h, input int v);
      return (h == 3 && v == 2) || (h == 0 && v == 0) || (h == 7 && v == 1);
   endfunction

   function automatic logic [11:0] pix_rgb(input int h, input int v);
      logic [3:0] hh;
      logic [3:0] vv;
      hh = 4'(h);
      vv = 4'(v);
      return is_key(h, v) ? KEY : {hh, vv, 4'hA};
   endfunction

   task automatic drive_pixel();
      int idx, h, v;
      idx = drv_abs % FT;
      h   = idx % HT;
      v   = idx / HT;
      in_if.hcount = 12'(h);
      in_if.vcount = 12'(v);
      in_if.hsync  = (h == HT - 2);
      in_if.vsync  = (v == VT - 1);
      in_if.hblnk  = (h >= HA);
      in_if.vblnk  = (v >= VA);
      in_if.rgb    = pix_rgb(h, v);
   endtask

   // raster source: new pixel every falling edge
   initial begin
      drive_pixel();
      forever begin
         @(negedge clk);
         drv_abs++;
         drive_pixel();
      end
   end

   always @(posedge clk) begin
      samp_abs <= drv_abs;
      samp_vec <= {in_if.hcount, in_if.vcount, in_if.hsync, in_if.vsync,
                   in_if.hblnk, in_if.vblnk, in_if.rgb};
      rst_s    <= rst;
   end

   always @(negedge clk) begin
      logic [39:0] ov;
      bit exp_p, exp_h;
      ov = {out_if.hcount, out_if.vcount, out_if.hsync, out_if.vsync,
            out_if.hblnk, out_if.vblnk, out_if.rgb};
      if (rst_s) begin
         q.delete();
         exp_count = 0;
         check("rst_out", 64'(ov), 64'd0);
         check("rst_hit", 64'(hit), 64'd0);
         check("rst_miss", 64'(miss), 64'd0);
         check("rst_count", 64'(hit_count), 64'd0);
      end else begin
         check("passthru", 64'(ov), 64'(samp_vec));
         exp_p = (q.size() > 0) && (q[0].abs == samp_abs);
         exp_h = exp_p && q[0].is_hit;
         check("hit", 64'(hit), 64'(exp_h));
         check("miss", 64'(miss), 64'(exp_p && !exp_h));
         check("hit_count", 64'(hit_count), 64'(exp_count));
         if (exp_p) begin
            void'(q.pop_front());
            if (exp_h && exp_count < 255) exp_count++;
         end
      end
   end

   // Click presented at the next rising edge; expectation queued if the stage
   // is expected to be idle there.
   task automatic do_shot(input int x, input int y);
      int a0, a, e, fsn, idx;
      bit vis, done, res_hit;
      @(negedge clk);
      #1;
      x_pos = 12'(x);
      y_pos = 12'(y);
      left  = 1'b1;
      a0    = drv_abs;
      if (a0 > busy_until) begin
         vis = (x < HA) && (y < VA);
         fsn = 0;
         a = a0;
         done = 0;
         res_hit = 0;
         while (!done) begin
            a++;
            idx = a % FT;
            if (vis && (idx % HT) == x && (idx / HT) == y) begin
               res_hit = is_key(x, y);
               done = 1;
            end else if (idx == 0) begin
               fsn++;
               if (fsn == 2) done = 1;
            end
         end
         q.push_back('{abs: a, is_hit: res_hit});
         last_res = a;
         e = a + 1;
         fsn = 0;
         while (fsn < 2) begin
            e++;
            if (e % FT == 0) fsn++;
         end
         busy_until = e;
      end
      @(negedge clk);
      #1;
      left = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (drv_abs <= busy_until + 1 && n < 600) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 600) check("wait_idle", 64'(drv_abs), 64'(busy_until + 2));
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      #1;
      rst = 1'b1;
      repeat (n) @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;
      busy_until = drv_abs;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      left  = 1'b0;
      x_pos = '0;
      y_pos = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;
      busy_until = drv_abs;
      repeat (5) @(negedge clk);

      // hit, plain miss, off-screen timeout, blanked key pixel, frame-start pixel
      do_shot(3, 2);  wait_idle();
      do_shot(1, 1);  wait_idle();
      do_shot(9, 1);  wait_idle();
      do_shot(7, 1);  wait_idle();
      do_shot(0, 0);  wait_idle();

      // clicks while armed and during cooldown are ignored
      do_shot(3, 2);
      do_shot(1, 1);
      while (drv_abs <= last_res + 3) @(negedge clk);
      #1;
      do_shot(1, 3);
      check("x_latch", 64'(dut.x_l), 64'd3);
      check("y_latch", 64'(dut.y_l), 64'd2);
      wait_idle();
      do_shot(1, 1);  wait_idle();

      // button held through reset must not fire
      x_pos = 12'd3;
      y_pos = 12'd2;
      left  = 1'b1;
      do_reset(3);
      repeat (5) @(negedge clk);
      #1;
      left = 1'b0;
      repeat (150) @(negedge clk);

      // saturation
      for (int i = 0; i < 300 && exp_count < 255; i++) begin
         wait_idle();
         do_shot(3, 2);
      end
      wait_idle();
      do_shot(3, 2);
      wait_idle();
      check("saturate", 64'(hit_count), 64'd255);

      // reset while armed
      do_shot(9, 0);
      repeat (3) @(negedge clk);
      do_reset(3);
      repeat (150) @(negedge clk);
      check("mid_rst_count", 64'(hit_count), 64'd0);
      #1;
      do_shot(3, 2);
      wait_idle();
      check("post_rst_count", 64'(hit_count), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
